apb_tmu_regbank: RTL

// - Parametrised APB3 register bank between the APB bus and NCH accelerator channels (CORDIC, PID, ...).
// - Each channel has:
//     - an output register with a one-cycle write strobe;
//     - an input capture register loaded by a valid pulse, with sticky NEW and OVR status bits.
// - Adds read wait states, PSLVERR on unmapped addresses and an optional interrupt.

---
 rtl/apb_tmu_regbank_if.sv | 29 ++
 rtl/apb_tmu_regbank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/apb_tmu_regbank_if.sv
// ---------------------------------------------------------------------------
// apb_tmu_regbank_if
// APB3 bus bundle for the TMU register bank.
//   PSEL, PENABLE, PWRITE  transfer control (master -> slave)
//   PADDR, PWDATA          32-bit address / write data (master -> slave)
//   PRDATA                 32-bit read data (slave -> master)
//   PREADY, PSLVERR        completion handshake and error (slave -> master)
// Modports: master (bus initiator), slave (register bank).
// ---------------------------------------------------------------------------
interface apb_tmu_regbank_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_tmu_regbank.sv
// ---------------------------------------------------------------------------
// apb_tmu_regbank
// APB3 register bank between the bus and NCH accelerator channels. Each
// channel owns an output register (with a one-cycle write strobe) and an
// input capture register (loaded by a valid pulse, with sticky NEW/OVR bits).
//
// Ports:
//   PCLK, PRESETn  clock and synchronous active-low reset
//   apb            APB3 slave port (apb_tmu_regbank_if.slave)
//   out_data       NCH*DW output registers, channel i at [i*DW +: DW]
//   out_wr         per-channel strobe, high the cycle after an OUT_i write
//   in_data        NCH*IW capture inputs, channel i at [i*IW +: IW]
//   in_vld         per-channel capture pulse
//   irq            level interrupt (only with APB_TMU_IRQ_EN)
//
// Address map (word offset = PADDR[11:2]):
//   0x000+i OUT_i RW, 0x040+i IN_i RO (read clears NEW[i]),
//   0x080 STAT {OVR,NEW} with W1C on OVR, 0x081 CTRL irq mask.
//
// Build option: define APB_TMU_IRQ_EN to map CTRL and add the irq output.
// ---------------------------------------------------------------------------
module apb_tmu_regbank #(
  parameter int NCH     = 5,
  parameter int DW      = 12,
  parameter int IW      = 17,
  parameter int RD_WAIT = 0
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_tmu_regbank_if.slave    apb,
  output logic [NCH*DW-1:0]   out_data,
  output logic [NCH-1:0]      out_wr,
  input  logic [NCH*IW-1:0]   in_data,
  input  logic [NCH-1:0]      in_vld
`ifdef APB_TMU_IRQ_EN
  ,
  output logic                irq
`endif
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e              state_q, state_d;
  logic [1:0]          wcnt_q, wcnt_d;
  logic [NCH*DW-1:0]   out_data_q, out_data_d;
  logic [NCH-1:0]      out_wr_q, out_wr_d;
  logic [NCH*IW-1:0]   cap_q, cap_d;
  logic [NCH-1:0]      new_q, new_d;
  logic [NCH-1:0]      ovr_q, ovr_d;

  logic [9:0]          addr_w;
  logic [3:0]          idx;
  logic                idx_ok;
  logic                hit_out, hit_in, hit_stat, hit_ctrl, mapped;
  logic                access_rd, pready, complete, wr_done, rd_done;
  logic [31:0]         rdata;
  logic [15:0]         new16, ovr16;
  logic                unused_bits;

  assign addr_w = apb.PADDR[11:2];
  assign idx    = addr_w[3:0];
  assign idx_ok = int'(idx) < NCH;

  assign hit_out  = (addr_w[9:4] == 6'h00) && idx_ok;
  assign hit_in   = (addr_w[9:4] == 6'h04) && idx_ok;
  assign hit_stat = (addr_w == 10'h080);
`ifdef APB_TMU_IRQ_EN
  assign hit_ctrl = (addr_w == 10'h081);
`else
  assign hit_ctrl = 1'b0;
`endif
  assign mapped = hit_out | hit_in | hit_stat | hit_ctrl;

  assign unused_bits = ^{apb.PADDR[31:12], apb.PADDR[1:0], apb.PWDATA};

  // Wait states are keyed off the live bus phase rather than the FSM, so a
  // master that idles an odd number of cycles between transfers still gets
  // exactly RD_WAIT stalls per read.
  assign access_rd = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
  assign pready    = ~(access_rd && (int'(wcnt_q) < RD_WAIT));
  assign complete  = apb.PSEL & apb.PENABLE & pready;
  assign wr_done   = complete & apb.PWRITE;
  assign rd_done   = complete & ~apb.PWRITE;

  // Bus FSM next state; after a completion with PSEL still high the next
  // cycle is taken as the setup phase of a back-to-back transfer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (apb.PSEL && !apb.PENABLE) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready) state_d = apb.PSEL ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Wait counter: counts stalled read cycles, cleared on completion or when
  // the master drops PSEL.
  always_comb begin
    wcnt_d = wcnt_q;
    if (complete || !apb.PSEL) wcnt_d = 2'd0;
    else if (access_rd)        wcnt_d = wcnt_q + 2'd1;
  end

  assign new16 = 16'(new_q);
  assign ovr16 = 16'(ovr_q);

`ifdef APB_TMU_IRQ_EN
  logic [NCH-1:0] ctrl_q, ctrl_d;
  logic           irq_q, irq_d;

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_done && hit_ctrl) ctrl_d = apb.PWDATA[NCH-1:0];
    irq_d = (|(new_q & ctrl_q)) | (|ovr_q);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  // Read mux; everything is zero-extended to 32 bits.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (hit_out && idx == 4'(i)) rdata[DW-1:0] = out_data_q[i*DW +: DW];
      if (hit_in  && idx == 4'(i)) rdata[IW-1:0] = cap_q[i*IW +: IW];
    end
    if (hit_stat) rdata = {ovr16, new16};
`ifdef APB_TMU_IRQ_EN
    if (hit_ctrl) rdata[NCH-1:0] = ctrl_q;
`endif
  end

  assign apb.PRDATA  = access_rd ? rdata : 32'd0;
  assign apb.PREADY  = pready;
  assign apb.PSLVERR = complete & ~mapped;

  // Channel registers. A completing IN_i read and a capture in the same cycle
  // leave NEW set and OVR untouched (the reader saw the old value); a capture
  // that overruns beats a simultaneous W1C of OVR.
  always_comb begin
    out_data_d = out_data_q;
    out_wr_d   = '0;
    cap_d      = cap_q;
    new_d      = new_q;
    ovr_d      = ovr_q;
    for (int i = 0; i < NCH; i++) begin
      logic rd_clr, w1c;
      rd_clr = rd_done && hit_in && idx == 4'(i);
      w1c    = wr_done && hit_stat && apb.PWDATA[16+i];
      if (wr_done && hit_out && idx == 4'(i)) begin
        out_data_d[i*DW +: DW] = apb.PWDATA[DW-1:0];
        out_wr_d[i]            = 1'b1;
      end
      if (in_vld[i]) cap_d[i*IW +: IW] = in_data[i*IW +: IW];
      new_d[i] = in_vld[i] | (new_q[i] & ~rd_clr);
      ovr_d[i] = (in_vld[i] & new_q[i] & ~rd_clr) | (ovr_q[i] & ~w1c);
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      wcnt_q     <= 2'd0;
      out_data_q <= '0;
      out_wr_q   <= '0;
      cap_q      <= '0;
      new_q      <= '0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      out_data_q <= out_data_d;
      out_wr_q   <= out_wr_d;
      cap_q      <= cap_d;
      new_q      <= new_d;
      ovr_q      <= ovr_d;
    end
  end

  assign out_data = out_data_q;
  assign out_wr   = out_wr_q;

endmodule
